// File: rtl/wb_commit_stage.sv
// wb_commit_stage: commits a LANES-wide bundle once in-order long-latency results arrive.
// Define WB_DEBUG_EN to build the registered debug_* trace ports; otherwise they are tied to 0.
module wb_commit_stage #(
    parameter int LANES   = 2,
    parameter int DATA_W  = 32,
    parameter int RD_W    = 5,
    parameter int ECODE_W = 7
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      flush_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_pc,
    input  logic [LANES*32-1:0]       in_inst,
    input  logic [LANES*RD_W-1:0]     in_rd,
    input  logic [LANES-1:0]          in_we,
    input  logic [LANES*2-1:0]        in_kind,
    input  logic [LANES*DATA_W-1:0]   in_result,
    input  logic [LANES-1:0]          in_exc,
    input  logic [LANES*ECODE_W-1:0]  in_ecode,
    input  logic [LANES*DATA_W-1:0]   in_badv,
    input  logic                      cpu_interrupt,
    input  logic [DATA_W-1:0]         eentry,
    input  logic [DATA_W-1:0]         tlbrentry,
    input  logic                      resp_valid,
    input  logic [DATA_W-1:0]         resp_data,
    output logic [LANES-1:0]          wb_we,
    output logic [LANES*RD_W-1:0]     wb_rd,
    output logic [LANES*DATA_W-1:0]   wb_data,
    output logic                      exc_commit,
    output logic [ECODE_W-1:0]        exc_ecode,
    output logic [DATA_W-1:0]         era_out,
    output logic                      wen_era,
    output logic [DATA_W-1:0]         badv_out,
    output logic                      wen_badv,
    output logic [18:0]               vppn_out,
    output logic                      wen_vppn,
    output logic                      tlb_exc,
    output logic [DATA_W-1:0]         pc_redirect,
    output logic [LANES*32-1:0]       debug_wb_pc,
    output logic [LANES*32-1:0]       debug_wb_inst,
    output logic [LANES*4-1:0]        debug_wb_rf_wen,
    output logic [LANES*RD_W-1:0]     debug_wb_rf_wnum,
    output logic [LANES*DATA_W-1:0]   debug_wb_rf_wdata,
    output logic [LANES-1:0]          debug_valid
);

    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [ECODE_W-1:0] EC_INT  = ECODE_W'(8'h00);
    localparam logic [ECODE_W-1:0] EC_PIL  = ECODE_W'(8'h01);
    localparam logic [ECODE_W-1:0] EC_PIS  = ECODE_W'(8'h02);
    localparam logic [ECODE_W-1:0] EC_PIF  = ECODE_W'(8'h03);
    localparam logic [ECODE_W-1:0] EC_PME  = ECODE_W'(8'h04);
    localparam logic [ECODE_W-1:0] EC_PPI  = ECODE_W'(8'h07);
    localparam logic [ECODE_W-1:0] EC_ADEF = ECODE_W'(8'h08);
    localparam logic [ECODE_W-1:0] EC_ALE  = ECODE_W'(8'h09);
    localparam logic [ECODE_W-1:0] EC_TLBR = ECODE_W'(8'h3f);

    function automatic logic [PW-1:0] lowest(input logic [LANES-1:0] m);
        logic [PW-1:0] r;
        r = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i]) r = PW'(i);
        end
        return r;
    endfunction

    function automatic logic is_page_exc(input logic [ECODE_W-1:0] e);
        return (e == EC_PIL) || (e == EC_PIS) || (e == EC_PIF) ||
               (e == EC_PME) || (e == EC_PPI) || (e == EC_TLBR);
    endfunction

    function automatic logic has_badv(input logic [ECODE_W-1:0] e);
        return is_page_exc(e) || (e == EC_ADEF) || (e == EC_ALE);
    endfunction

    logic [1:0]                         state_q, state_d;
    logic [LANES-1:0]                   pend_q, pend_d;
    logic [PW-1:0]                      ptr_q, ptr_d;
    logic [LANES-1:0][RD_W-1:0]         rd_q, rd_d;
    logic [LANES-1:0]                   wen_q, wen_d;
    logic [LANES-1:0]                   live_q, live_d;
    logic [LANES-1:0][DATA_W-1:0]       data_q, data_d;
    logic                               exc_q, exc_d;
    logic [ECODE_W-1:0]                 ecode_q, ecode_d;
    logic [DATA_W-1:0]                  era_q, era_d;
    logic [DATA_W-1:0]                  badv_q, badv_d;

    logic                               acc;
    logic                               seen;
    logic [LANES-1:0]                   in_live;
    logic [LANES-1:0]                   in_pend;
    logic [LANES-1:0]                   in_wen;
    logic [ECODE_W-1:0]                 in_ecode_k;
    logic [DATA_W-1:0]                  in_era_k;
    logic [DATA_W-1:0]                  in_badv_k;
    logic                               commit_d;
    logic                               exc_wb;

    assign in_ready = ((state_q == S_IDLE) || (state_q == S_COMMIT)) && !flush_in;
    assign acc      = in_valid && in_ready;

    // Kill point: an interrupt claims lane 0, else the lowest faulting lane.
    always_comb begin
        in_ecode_k = EC_INT;
        in_era_k   = in_pc[0 +: DATA_W];
        in_badv_k  = in_badv[0 +: DATA_W];
        if (!cpu_interrupt) begin
            for (int i = LANES - 1; i >= 0; i--) begin
                if (in_exc[i]) begin
                    in_ecode_k = in_ecode[i*ECODE_W +: ECODE_W];
                    in_era_k   = in_pc[i*DATA_W +: DATA_W];
                    in_badv_k  = in_badv[i*DATA_W +: DATA_W];
                end
            end
        end
        seen = cpu_interrupt;
        for (int i = 0; i < LANES; i++) begin
            seen       = seen | in_exc[i];
            in_live[i] = !seen;
            in_pend[i] = in_live[i] && (in_kind[i*2 +: 2] != 2'b00);
            in_wen[i]  = in_live[i] && in_we[i] &&
                         (in_rd[i*RD_W +: RD_W] != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ptr_d   = ptr_q;
        rd_d    = rd_q;
        wen_d   = wen_q;
        live_d  = live_q;
        data_d  = data_q;
        exc_d   = exc_q;
        ecode_d = ecode_q;
        era_d   = era_q;
        badv_d  = badv_q;
        if (flush_in) begin
            state_d = S_IDLE;
            pend_d  = '0;
            ptr_d   = '0;
        end else if (state_q == S_WAIT) begin
            if (resp_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    if (PW'(i) == ptr_q) data_d[i] = resp_data;
                end
                pend_d = pend_q & ~(LANES'(1) << ptr_q);
                ptr_d  = lowest(pend_d);
                if (pend_d == '0) state_d = S_COMMIT;
            end
        end else if (acc) begin
            rd_d    = in_rd;
            wen_d   = in_wen;
            live_d  = in_live;
            data_d  = in_result;
            exc_d   = cpu_interrupt || (|in_exc);
            ecode_d = in_ecode_k;
            era_d   = in_era_k;
            badv_d  = in_badv_k;
            pend_d  = in_pend;
            ptr_d   = lowest(in_pend);
            state_d = (|in_pend) ? S_WAIT : S_COMMIT;
        end else begin
            state_d = S_IDLE;
        end
    end

    assign commit_d = (state_d == S_COMMIT);
    assign exc_wb   = commit_d && exc_d;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            ptr_q       <= '0;
            rd_q        <= '0;
            wen_q       <= '0;
            live_q      <= '0;
            data_q      <= '0;
            exc_q       <= 1'b0;
            ecode_q     <= '0;
            era_q       <= '0;
            badv_q      <= '0;
            wb_we       <= '0;
            wb_rd       <= '0;
            wb_data     <= '0;
            exc_commit  <= 1'b0;
            exc_ecode   <= '0;
            era_out     <= '0;
            wen_era     <= 1'b0;
            badv_out    <= '0;
            wen_badv    <= 1'b0;
            vppn_out    <= '0;
            wen_vppn    <= 1'b0;
            tlb_exc     <= 1'b0;
            pc_redirect <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ptr_q       <= ptr_d;
            rd_q        <= rd_d;
            wen_q       <= wen_d;
            live_q      <= live_d;
            data_q      <= data_d;
            exc_q       <= exc_d;
            ecode_q     <= ecode_d;
            era_q       <= era_d;
            badv_q      <= badv_d;
            wb_we       <= commit_d ? wen_d : '0;
            wb_rd       <= commit_d ? rd_d : '0;
            wb_data     <= commit_d ? data_d : '0;
            exc_commit  <= exc_wb;
            exc_ecode   <= exc_wb ? ecode_d : '0;
            era_out     <= exc_wb ? era_d : '0;
            wen_era     <= exc_wb;
            badv_out    <= exc_wb ? badv_d : '0;
            wen_badv    <= exc_wb && has_badv(ecode_d);
            vppn_out    <= exc_wb ? badv_d[31:13] : '0;
            wen_vppn    <= exc_wb && is_page_exc(ecode_d);
            tlb_exc     <= exc_wb && (ecode_d == EC_TLBR);
            pc_redirect <= exc_wb ? ((ecode_d == EC_TLBR) ? tlbrentry : eentry) : '0;
        end
    end

`ifdef WB_DEBUG_EN
    logic [LANES-1:0][DATA_W-1:0] pc_q;
    logic [LANES-1:0][31:0]       inst_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            pc_q              <= '0;
            inst_q            <= '0;
            debug_wb_pc       <= '0;
            debug_wb_inst     <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
            debug_valid       <= '0;
        end else begin
            if (acc && !flush_in) begin
                pc_q   <= in_pc;
                inst_q <= in_inst;
            end
            for (int i = 0; i < LANES; i++) begin
                debug_wb_pc[i*32 +: 32] <=
                    commit_d ? 32'((acc ? in_pc[i*DATA_W +: DATA_W] : pc_q[i])) : '0;
                debug_wb_inst[i*32 +: 32] <=
                    commit_d ? (acc ? in_inst[i*32 +: 32] : inst_q[i]) : '0;
                debug_wb_rf_wen[i*4 +: 4] <= commit_d ? {3'b000, wen_d[i]} : 4'b0000;
            end
            debug_wb_rf_wnum  <= commit_d ? rd_d : '0;
            debug_wb_rf_wdata <= commit_d ? data_d : '0;
            debug_valid       <= commit_d ? live_d : '0;
        end
    end
`else
    logic unused_dbg;
    assign unused_dbg        = ^{in_inst, live_q};
    assign debug_wb_pc       = '0;
    assign debug_wb_inst     = '0;
    assign debug_wb_rf_wen   = '0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
    assign debug_valid       = '0;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage with LANES=2 and the debug ports disabled.
module tb_wb_commit_stage;

    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int EW    = 7;

    logic                   clk = 1'b0;
    logic                   aresetn;
    logic                   flush_in;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*DW-1:0]    in_pc;
    logic [LANES*32-1:0]    in_inst;
    logic [LANES*RW-1:0]    in_rd;
    logic [LANES-1:0]       in_we;
    logic [LANES*2-1:0]     in_kind;
    logic [LANES*DW-1:0]    in_result;
    logic [LANES-1:0]       in_exc;
    logic [LANES*EW-1:0]    in_ecode;
    logic [LANES*DW-1:0]    in_badv;
    logic                   cpu_interrupt;
    logic [DW-1:0]          eentry;
    logic [DW-1:0]          tlbrentry;
    logic                   resp_valid;
    logic [DW-1:0]          resp_data;
    logic [LANES-1:0]       wb_we;
    logic [LANES*RW-1:0]    wb_rd;
    logic [LANES*DW-1:0]    wb_data;
    logic                   exc_commit;
    logic [EW-1:0]          exc_ecode;
    logic [DW-1:0]          era_out;
    logic                   wen_era;
    logic [DW-1:0]          badv_out;
    logic                   wen_badv;
    logic [18:0]            vppn_out;
    logic                   wen_vppn;
    logic                   tlb_exc;
    logic [DW-1:0]          pc_redirect;
    logic [LANES*32-1:0]    debug_wb_pc;
    logic [LANES*32-1:0]    debug_wb_inst;
    logic [LANES*4-1:0]     debug_wb_rf_wen;
    logic [LANES*RW-1:0]    debug_wb_rf_wnum;
    logic [LANES*DW-1:0]    debug_wb_rf_wdata;
    logic [LANES-1:0]       debug_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_commit_stage #(.LANES(LANES), .DATA_W(DW), .RD_W(RW), .ECODE_W(EW)) dut (
        .clk(clk), .aresetn(aresetn), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_rd(in_rd), .in_we(in_we),
        .in_kind(in_kind), .in_result(in_result), .in_exc(in_exc),
        .in_ecode(in_ecode), .in_badv(in_badv),
        .cpu_interrupt(cpu_interrupt), .eentry(eentry), .tlbrentry(tlbrentry),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_commit(exc_commit), .exc_ecode(exc_ecode),
        .era_out(era_out), .wen_era(wen_era),
        .badv_out(badv_out), .wen_badv(wen_badv),
        .vppn_out(vppn_out), .wen_vppn(wen_vppn),
        .tlb_exc(tlb_exc), .pc_redirect(pc_redirect),
        .debug_wb_pc(debug_wb_pc), .debug_wb_inst(debug_wb_inst),
        .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata), .debug_valid(debug_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        in_valid      = 1'b0;
        in_pc         = '0;
        in_inst       = '0;
        in_rd         = '0;
        in_we         = '0;
        in_kind       = '0;
        in_result     = '0;
        in_exc        = '0;
        in_ecode      = '0;
        in_badv       = '0;
        cpu_interrupt = 1'b0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        flush_in      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        aresetn   = 1'b0;
        eentry    = 32'h1c008000;
        tlbrentry = 32'h1c00f000;
        tick();
        tick();
        chk("rst_wb_we", 64'(wb_we), 64'h0);
        chk("rst_wb_data", wb_data, 64'h0);
        chk("rst_exc", 64'(exc_commit), 64'h0);
        chk("rst_era", 64'(era_out), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        @(negedge clk);
        aresetn = 1'b1;

        // three back-to-back ALU bundles
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_pc     = {32'h1c000004, 32'h1c000000};
            in_rd     = {5'd4, 5'd3};
            in_we     = 2'b11;
            in_kind   = 4'b0000;
            in_result = {32'h22 + 32'(j), 32'h11 + 32'(j)};
            tick();
            chk("alu_we", 64'(wb_we), 64'h3);
            chk("alu_data", wb_data, {32'h22 + 32'(j), 32'h11 + 32'(j)});
            chk("alu_rd", 64'(wb_rd), 64'({5'd4, 5'd3}));
            chk("alu_noexc", 64'(exc_commit), 64'h0);
        end
        @(negedge clk);
        clr();
        tick();
        chk("alu_oneshot", 64'(wb_we), 64'h0);

        // lane0 div, lane1 load
        @(negedge clk);
        in_valid = 1'b1;
        in_rd    = {5'd6, 5'd5};
        in_we    = 2'b11;
        in_kind  = {2'b01, 2'b10};
        tick();
        chk("ll_ready", 64'(in_ready), 64'h0);
        chk("ll_wait_we", 64'(wb_we), 64'h0);
        @(negedge clk);
        clr();
        resp_valid = 1'b1;
        resp_data  = 32'hA;
        tick();
        chk("ll_r1_we", 64'(wb_we), 64'h0);
        @(negedge clk);
        resp_valid = 1'b0;
        tick();
        chk("ll_gap_we", 64'(wb_we), 64'h0);
        chk("ll_gap_ready", 64'(in_ready), 64'h0);
        @(negedge clk);
        resp_valid = 1'b1;
        resp_data  = 32'hB;
        tick();
        chk("ll_we", 64'(wb_we), 64'h3);
        chk("ll_data", wb_data, {32'hB, 32'hA});
        chk("ll_rd", 64'(wb_rd), 64'({5'd6, 5'd5}));
        @(negedge clk);
        clr();
        tick();
        chk("ll_oneshot", 64'(wb_we), 64'h0);

        // lane1 ALE
        @(negedge clk);
        in_valid  = 1'b1;
        in_pc     = {32'h1c000104, 32'h1c000100};
        in_rd     = {5'd8, 5'd7};
        in_we     = 2'b11;
        in_result = {32'h44, 32'h33};
        in_exc    = 2'b10;
        in_ecode  = {7'h09, 7'h00};
        in_badv   = {32'h1003, 32'h0};
        tick();
        chk("ale_we", 64'(wb_we), 64'h1);
        chk("ale_exc", 64'(exc_commit), 64'h1);
        chk("ale_era", 64'(era_out), 64'h1c000104);
        chk("ale_wen_era", 64'(wen_era), 64'h1);
        chk("ale_ecode", 64'(exc_ecode), 64'h09);
        chk("ale_badv", 64'(badv_out), 64'h1003);
        chk("ale_wen_badv", 64'(wen_badv), 64'h1);
        chk("ale_wen_vppn", 64'(wen_vppn), 64'h0);
        chk("ale_tlb", 64'(tlb_exc), 64'h0);
        chk("ale_redirect", 64'(pc_redirect), 64'h1c008000);

        // lane0 TLBR
        @(negedge clk);
        clr();
        in_valid = 1'b1;
        in_pc    = {32'h1c000304, 32'h1c000300};
        in_rd    = {5'd2, 5'd1};
        in_we    = 2'b11;
        in_exc   = 2'b01;
        in_ecode = {7'h00, 7'h3f};
        in_badv  = {32'h0, 32'h12346000};
        tick();
        chk("tlbr_we", 64'(wb_we), 64'h0);
        chk("tlbr_tlb", 64'(tlb_exc), 64'h1);
        chk("tlbr_redirect", 64'(pc_redirect), 64'h1c00f000);
        chk("tlbr_wen_vppn", 64'(wen_vppn), 64'h1);
        chk("tlbr_vppn", 64'(vppn_out), 64'h091a3);
        chk("tlbr_era", 64'(era_out), 64'h1c000300);

        // flush while one response is still outstanding
        @(negedge clk);
        clr();
        in_valid = 1'b1;
        in_rd    = {5'd10, 5'd9};
        in_we    = 2'b11;
        in_kind  = {2'b01, 2'b01};
        tick();
        @(negedge clk);
        clr();
        resp_valid = 1'b1;
        resp_data  = 32'hC;
        tick();
        @(negedge clk);
        resp_valid = 1'b0;
        flush_in   = 1'b1;
        #1;
        chk("fl_ready_low", 64'(in_ready), 64'h0);
        tick();
        chk("fl_we", 64'(wb_we), 64'h0);
        chk("fl_exc", 64'(exc_commit), 64'h0);
        @(negedge clk);
        flush_in   = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'hD;
        tick();
        chk("fl_stray_we", 64'(wb_we), 64'h0);
        chk("fl_stray_exc", 64'(exc_commit), 64'h0);
        chk("fl_idle_ready", 64'(in_ready), 64'h1);
        @(negedge clk);
        clr();

        // interrupt at accept
        @(negedge clk);
        in_valid      = 1'b1;
        cpu_interrupt = 1'b1;
        in_pc         = {32'h1c000204, 32'h1c000200};
        in_rd         = {5'd12, 5'd11};
        in_we         = 2'b11;
        in_result     = {32'h66, 32'h55};
        in_ecode      = {7'h09, 7'h09};
        tick();
        chk("int_we", 64'(wb_we), 64'h0);
        chk("int_exc", 64'(exc_commit), 64'h1);
        chk("int_ecode", 64'(exc_ecode), 64'h0);
        chk("int_era", 64'(era_out), 64'h1c000200);
        chk("int_wen_badv", 64'(wen_badv), 64'h0);
        chk("int_dbg_valid", 64'(debug_valid), 64'h0);
        chk("int_dbg_pc", debug_wb_pc, 64'h0);
        chk("int_dbg_wen", 64'(debug_wb_rf_wen), 64'h0);
        chk("int_dbg_wdata", debug_wb_rf_wdata, 64'h0);
        @(negedge clk);
        clr();
        tick();
        chk("int_oneshot", 64'(exc_commit), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
